// File: rtl/line_buf_rd.sv
// line_buf_rd: read-side controller for the pixel line buffer RAM.
// Streams line_len consecutive words from base_addr as a valid/ready pixel
// stream. The RAM's one-cycle read latency is hidden by a two-entry output
// FIFO, so one pixel per clock is sustained even under backpressure.
module line_buf_rd #(
  parameter int ADDR_W = 12,
  parameter int PIX_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] line_len,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [PIX_W:0]    ram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [PIX_W-1:0]  m_pix,
  output logic              m_flag,
  output logic              m_last
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] beat_idx;
  logic              inflight;

  logic [PIX_W:0]    fifo_mem [2];
  logic              wr_sel;
  logic              rd_sel;
  logic [1:0]        fifo_cnt;

  logic              push;
  logic              pop;
  logic              room;

  // A read returns one cycle after ram_en; it always lands in the FIFO.
  assign push = inflight;
  assign pop  = m_valid && m_ready;

  // Reads already in the FIFO plus the one in flight must leave a free slot,
  // unless a beat leaves this cycle (deliberate m_ready -> ram_en path).
  assign room   = ({1'b0, fifo_cnt} + {2'b00, inflight}) < 3'd2;
  assign ram_en = (state == READ) && (remaining != '0) && (room || pop);

  assign ram_addr = rd_ptr;
  assign m_valid  = (fifo_cnt != 2'd0);
  assign m_pix    = fifo_mem[rd_sel][PIX_W-1:0];
  assign m_flag   = fifo_mem[rd_sel][PIX_W];
  assign m_last   = m_valid && (beat_idx == last_idx);

  // Line sequencer: captures the request, walks the read pointer, signals completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      remaining <= '0;
      last_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            rd_ptr    <= base_addr;
            remaining <= line_len;
            last_idx  <= line_len - ADDR_W'(1);
            if (line_len == '0) begin
              done <= 1'b1;
            end else begin
              state <= READ;
              busy  <= 1'b1;
            end
          end
        end
        READ: begin
          if (ram_en) begin
            rd_ptr    <= rd_ptr + ADDR_W'(1);
            remaining <= remaining - ADDR_W'(1);
            if (remaining == ADDR_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Beat index within the current line, used to mark the final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx <= '0;
    end else if (state == IDLE && start) begin
      beat_idx <= '0;
    end else if (pop) begin
      beat_idx <= beat_idx + ADDR_W'(1);
    end
  end

  // Track whether the RAM output register holds a word for us next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= ram_en;
    end
  end

  // Two-entry output FIFO; push and pop may happen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_sel] <= ram_dout;
        wr_sel           <= ~wr_sel;
      end
      if (pop) rd_sel <= ~rd_sel;
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // The issue rule keeps the FIFO from overflowing; catch any push into a full FIFO.
  always_ff @(posedge clk) begin
    if (rst_n && push && !pop) assert (fifo_cnt != 2'd2);
  end

endmodule
